// File: rtl/core_types_pkg.sv
// ============================================================================
// Module      : core_types_pkg
// Description : Shared UPCT sizing constants and index/data types.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_types_pkg;

    localparam int UPCT_ENTRIES     = 8;
    localparam int LOG_UPCT_ENTRIES = $clog2(UPCT_ENTRIES);
    localparam int UPPER_PC_WIDTH   = 21;

    typedef logic [UPPER_PC_WIDTH-1:0]   upper_pc_t;
    typedef logic [LOG_UPCT_ENTRIES-1:0] upct_idx_t;

endpackage

`default_nettype wire

// File: rtl/plru_tree.sv
// ============================================================================
// Module      : plru_tree
// Description : Heap-ordered tree pseudo-LRU state with victim output and touch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module plru_tree #(
    parameter int ENTRIES     = 8,
    parameter int LOG_ENTRIES = $clog2(ENTRIES)
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   touch_valid,
    input  logic [LOG_ENTRIES-1:0] touch_index,
    output logic [LOG_ENTRIES-1:0] victim_index
);

    // ENTRIES-1 tree nodes; the top bit is a spare so node ids fit LOG_ENTRIES bits.
    logic [ENTRIES-1:0] tree_q;
    logic [ENTRIES-1:0] tree_d;

    always_comb begin
        logic [LOG_ENTRIES-1:0] node;
        logic                   dir;
        node         = '0;
        dir          = 1'b0;
        victim_index = '0;
        for (int l = 0; l < LOG_ENTRIES; l++) begin
            dir                           = tree_q[node];
            victim_index[LOG_ENTRIES-1-l] = dir;
            node = (node << 1) + LOG_ENTRIES'(1) + LOG_ENTRIES'(dir);
        end
    end

    // Each node on the touched path points away from the touched leaf.
    always_comb begin
        logic [LOG_ENTRIES-1:0] node;
        logic                   dir;
        node   = '0;
        dir    = 1'b0;
        tree_d = tree_q;
        if (touch_valid) begin
            for (int l = 0; l < LOG_ENTRIES; l++) begin
                dir          = touch_index[LOG_ENTRIES-1-l];
                tree_d[node] = ~dir;
                node = (node << 1) + LOG_ENTRIES'(1) + LOG_ENTRIES'(dir);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            tree_q <= '0;
        end else begin
            tree_q <= tree_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/upct_plru_param.sv
// ============================================================================
// Module      : upct_plru_param
// Description : Parametrised upper-PC table with dedup, fill-invalid-first and
//               tree-PLRU replacement; 1-cycle read and update ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module upct_plru_param #(
    parameter int UPCT_ENTRIES     = core_types_pkg::UPCT_ENTRIES,
    parameter int LOG_UPCT_ENTRIES = $clog2(UPCT_ENTRIES),
    parameter int UPPER_PC_WIDTH   = core_types_pkg::UPPER_PC_WIDTH
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        read_valid,
    input  logic [LOG_UPCT_ENTRIES-1:0] read_index,
    output logic [UPPER_PC_WIDTH-1:0]   read_upper_pc,
    output logic                        read_upper_pc_valid,
    input  logic                        update_valid,
    input  logic [UPPER_PC_WIDTH-1:0]   update_upper_pc,
    output logic [LOG_UPCT_ENTRIES-1:0] update_index,
    output logic                        update_hit,
    output logic                        update_done
);

    logic [UPCT_ENTRIES-1:0]     valid_q;
    logic [UPPER_PC_WIDTH-1:0]   pc_q [UPCT_ENTRIES];

    logic [UPPER_PC_WIDTH-1:0]   rd_pc_q;
    logic                        rd_valid_q;
    logic [LOG_UPCT_ENTRIES-1:0] upd_idx_q;
    logic                        upd_hit_q;
    logic                        upd_done_q;

    logic                        hit_d;
    logic [LOG_UPCT_ENTRIES-1:0] hit_idx_d;
    logic                        free_any_d;
    logic [LOG_UPCT_ENTRIES-1:0] free_idx_d;
    logic [LOG_UPCT_ENTRIES-1:0] chosen_idx_d;
    logic [LOG_UPCT_ENTRIES-1:0] victim_idx;

    plru_tree #(
        .ENTRIES     (UPCT_ENTRIES),
        .LOG_ENTRIES (LOG_UPCT_ENTRIES)
    ) u_plru (
        .CLK          (CLK),
        .nRST         (nRST),
        .touch_valid  (update_valid),
        .touch_index  (chosen_idx_d),
        .victim_index (victim_idx)
    );

    // Descending scan so the lowest-numbered invalid entry wins.
    always_comb begin
        hit_d      = 1'b0;
        hit_idx_d  = '0;
        free_any_d = 1'b0;
        free_idx_d = '0;
        for (int i = UPCT_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_any_d = 1'b1;
                free_idx_d = LOG_UPCT_ENTRIES'(i);
            end
            if (valid_q[i] && (pc_q[i] == update_upper_pc)) begin
                hit_d     = 1'b1;
                hit_idx_d = LOG_UPCT_ENTRIES'(i);
            end
        end
        if (hit_d) begin
            chosen_idx_d = hit_idx_d;
        end else if (free_any_d) begin
            chosen_idx_d = free_idx_d;
        end else begin
            chosen_idx_d = victim_idx;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid_q    <= '0;
            for (int i = 0; i < UPCT_ENTRIES; i++) begin
                pc_q[i] <= '0;
            end
            rd_pc_q    <= '0;
            rd_valid_q <= 1'b0;
            upd_idx_q  <= '0;
            upd_hit_q  <= 1'b0;
            upd_done_q <= 1'b0;
        end else begin
            if (read_valid) begin
                rd_pc_q    <= pc_q[read_index];
                rd_valid_q <= valid_q[read_index];
            end
            upd_done_q <= update_valid;
            if (update_valid) begin
                upd_idx_q <= chosen_idx_d;
                upd_hit_q <= hit_d;
                if (!hit_d) begin
                    pc_q[chosen_idx_d]    <= update_upper_pc;
                    valid_q[chosen_idx_d] <= 1'b1;
                end
            end
        end
    end

    assign read_upper_pc       = rd_pc_q;
    assign read_upper_pc_valid = rd_valid_q;
    assign update_index        = upd_idx_q;
    assign update_hit          = upd_hit_q;
    assign update_done         = upd_done_q;

endmodule

`default_nettype wire

// File: tb/tb_upct_plru_param.sv
// ============================================================================
// Module      : tb_upct_plru_param
// Description : Directed vector bench for the 8-entry UPCT plus a 2/16-entry
//               sweep against a heap-walk tree-PLRU reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_upct_plru_param;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        rv;
    logic [3:0]  ridx;
    logic        uv;
    logic [20:0] upc;

    logic [20:0] r8_pc, r2_pc, r16_pc;
    logic        r8_v, r2_v, r16_v;
    logic [2:0]  u8_idx;
    logic [0:0]  u2_idx;
    logic [3:0]  u16_idx;
    logic        u8_hit, u2_hit, u16_hit;
    logic        u8_done, u2_done, u16_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    upct_plru_param dut8 (
        .CLK(CLK), .nRST(nRST), .read_valid(rv), .read_index(ridx[2:0]),
        .read_upper_pc(r8_pc), .read_upper_pc_valid(r8_v),
        .update_valid(uv), .update_upper_pc(upc),
        .update_index(u8_idx), .update_hit(u8_hit), .update_done(u8_done));

    upct_plru_param #(.UPCT_ENTRIES(2)) dut2 (
        .CLK(CLK), .nRST(nRST), .read_valid(rv), .read_index(ridx[0:0]),
        .read_upper_pc(r2_pc), .read_upper_pc_valid(r2_v),
        .update_valid(uv), .update_upper_pc(upc),
        .update_index(u2_idx), .update_hit(u2_hit), .update_done(u2_done));

    upct_plru_param #(.UPCT_ENTRIES(16)) dut16 (
        .CLK(CLK), .nRST(nRST), .read_valid(rv), .read_index(ridx),
        .read_upper_pc(r16_pc), .read_upper_pc_valid(r16_v),
        .update_valid(uv), .update_upper_pc(upc),
        .update_index(u16_idx), .update_hit(u16_hit), .update_done(u16_done));

    typedef struct {
        logic        rv;
        logic [2:0]  ridx;
        logic        uv;
        logic [20:0] upc;
        logic [20:0] e_rpc;
        logic        e_rv;
        logic [2:0]  e_idx;
        logic        e_hit;
        logic        e_done;
    } vec_t;

    localparam int NV = 25;
    vec_t vt [NV];

    // Reference model state: [0] models 2 entries, [1] models 16 entries.
    int   ment [2] = '{2, 16};
    bit   mv [2][16];
    logic [20:0] mp [2][16];
    int   mt [2][16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0; rv = 1'b0; uv = 1'b0; ridx = '0; upc = '0;
        tick();
        tick();
        nRST = 1'b1;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 16; i++) begin
                mv[m][i] = 1'b0; mp[m][i] = '0; mt[m][i] = 0;
            end
    endtask

    // Leaves sit at heap positions E-1..2E-2; walk down for victims, up for touches.
    task automatic model_upd(input int m, input logic [20:0] v, output int idx, output logic hit);
        int e;
        int node;
        int p;
        e = ment[m];
        idx = -1;
        hit = 1'b0;
        for (int i = 0; i < e; i++)
            if (mv[m][i] && mp[m][i] == v) begin idx = i; hit = 1'b1; end
        if (!hit) begin
            for (int i = e - 1; i >= 0; i--)
                if (!mv[m][i]) idx = i;
            if (idx < 0) begin
                node = 0;
                while (node < e - 1) node = 2 * node + 1 + mt[m][node];
                idx = node - (e - 1);
            end
            mv[m][idx] = 1'b1;
            mp[m][idx] = v;
        end
        node = idx + e - 1;
        while (node > 0) begin
            p = (node - 1) / 2;
            mt[m][p] = (node == 2 * p + 1) ? 1 : 0;
            node = p;
        end
    endtask

    initial begin
        int   e0, e1;
        logic h0, h1;
        logic [20:0] seen [16];
        bit          seen_v [16];
        int   dups;

        // fields: rv ridx uv upc | e_rpc e_rv e_idx e_hit e_done
        vt[0] = '{1'b1, 3'd3, 1'b0, 21'h0, 21'h0, 1'b0, 3'd0, 1'b0, 1'b0};
        for (int k = 0; k < 8; k++) begin
            vt[1 + k] = '{1'b0, 3'd0, 1'b1, 21'h100 + 21'(k), 21'h0, 1'b0, 3'(k), 1'b0, 1'b1};
            vt[9 + k] = '{1'b1, 3'(k), 1'b0, 21'h0, 21'h100 + 21'(k), 1'b1, 3'd7, 1'b0, 1'b0};
        end
        vt[17] = '{1'b1, 3'd3, 1'b1, 21'h103, 21'h103, 1'b1, 3'd3, 1'b1, 1'b1};
        // Tree after fill + touch(3): root points right, so the victim is 4.
        vt[18] = '{1'b0, 3'd0, 1'b1, 21'h200, 21'h103, 1'b1, 3'd4, 1'b0, 1'b1};
        vt[19] = '{1'b1, 3'd4, 1'b0, 21'h0, 21'h200, 1'b1, 3'd4, 1'b0, 1'b0};
        // Collision: read 0 while the next miss allocates victim 0.
        vt[20] = '{1'b1, 3'd0, 1'b1, 21'h300, 21'h100, 1'b1, 3'd0, 1'b0, 1'b1};
        vt[21] = '{1'b1, 3'd0, 1'b0, 21'h0, 21'h300, 1'b1, 3'd0, 1'b0, 1'b0};
        vt[22] = '{1'b1, 3'd3, 1'b1, 21'h200, 21'h103, 1'b1, 3'd4, 1'b1, 1'b1};
        vt[23] = '{1'b0, 3'd0, 1'b1, 21'h104, 21'h103, 1'b1, 3'd2, 1'b0, 1'b1};
        vt[24] = '{1'b1, 3'd2, 1'b0, 21'h0, 21'h104, 1'b1, 3'd2, 1'b0, 1'b0};

        do_reset();
        nRST = 1'b0;
        tick();
        chk("reset rpc", r8_pc, 0);
        chk("reset rv", r8_v, 0);
        chk("reset idx", u8_idx, 0);
        chk("reset hit", u8_hit, 0);
        chk("reset done", u8_done, 0);
        nRST = 1'b1;

        for (int k = 0; k < NV; k++) begin
            rv = vt[k].rv; ridx = {1'b0, vt[k].ridx}; uv = vt[k].uv; upc = vt[k].upc;
            tick();
            chk($sformatf("v%0d rpc", k), r8_pc, vt[k].e_rpc);
            chk($sformatf("v%0d rvalid", k), r8_v, vt[k].e_rv);
            chk($sformatf("v%0d idx", k), u8_idx, vt[k].e_idx);
            chk($sformatf("v%0d hit", k), u8_hit, vt[k].e_hit);
            chk($sformatf("v%0d done", k), u8_done, vt[k].e_done);
        end

        // Reset arriving with an update in flight drops that update.
        rv = 1'b0; uv = 1'b1; upc = 21'h555; nRST = 1'b0;
        tick();
        chk("midrst done", u8_done, 0);
        chk("midrst idx", u8_idx, 0);
        chk("midrst rpc", r8_pc, 0);
        nRST = 1'b1; uv = 1'b0; rv = 1'b1; ridx = 4'd0;
        tick();
        chk("midrst read valid", r8_v, 0);
        chk("midrst read pc", r8_pc, 0);
        rv = 1'b0; uv = 1'b1; upc = 21'h777;
        tick();
        chk("post-rst alloc idx", u8_idx, 0);
        chk("post-rst alloc hit", u8_hit, 0);
        chk("post-rst alloc done", u8_done, 1);

        // Sweep 2- and 16-entry builds against the reference model.
        do_reset();
        for (int c = 0; c < 60; c++) begin
            uv = 1'b1; rv = 1'b0;
            upc = 21'h400 + 21'($urandom_range(0, 23));
            model_upd(0, upc, e0, h0);
            model_upd(1, upc, e1, h1);
            tick();
            chk($sformatf("sw%0d e2 idx", c), u2_idx, e0);
            chk($sformatf("sw%0d e2 hit", c), u2_hit, h0);
            chk($sformatf("sw%0d e16 idx", c), u16_idx, e1);
            chk($sformatf("sw%0d e16 hit", c), u16_hit, h1);
        end
        uv = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rv = 1'b1; ridx = 4'(i);
            tick();
            seen[i] = r16_pc; seen_v[i] = r16_v;
            chk($sformatf("sw rd16[%0d] pc", i), r16_pc, mp[1][i]);
            chk($sformatf("sw rd16[%0d] v", i), r16_v, mv[1][i]);
            if (i < 2) begin
                chk($sformatf("sw rd2[%0d] pc", i), r2_pc, mp[0][i]);
                chk($sformatf("sw rd2[%0d] v", i), r2_v, mv[0][i]);
            end
        end
        dups = 0;
        for (int i = 0; i < 16; i++)
            for (int j = i + 1; j < 16; j++)
                if (seen_v[i] && seen_v[j] && seen[i] == seen[j]) dups++;
        chk("sw16 duplicates", dups, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
